// File: rtl/matrix_scan_driver.sv
// matrix_scan_driver: row scanner for the 16x16 LED matrix.
// Each row: LOAD the column bits, SHIFT {row one-hot, columns} MSB first into
// the cascaded shift registers, LATCH them, then light the row for DWELL clocks.
// Optional feature: define SCAN_BRIGHTNESS_EN to add a 4-bit brightness input
// that shortens the lit portion of each dwell window.
module matrix_scan_driver #(
  parameter int CLK_DIV = 4,
  parameter int DWELL   = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [15:0] grid_col,
`ifdef SCAN_BRIGHTNESS_EN
  input  logic [3:0]  brightness,
`endif
  output logic [15:0] grid_row,
  output logic        ser_data,
  output logic        ser_clk,
  output logic        ser_latch,
  output logic        oe_n,
  output logic        frame_start
);

  localparam int SHIFT_LAST = 2 * CLK_DIV - 1;
  localparam int CNT_MAX    = (2 * CLK_DIV > DWELL) ? 2 * CLK_DIV : DWELL;
  localparam int CW         = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_DWELL
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    row, row_nx;
  logic [4:0]    bit_cnt, bit_cnt_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0]   shreg, shreg_nx;
  logic          ser_data_nx, ser_clk_nx, ser_latch_nx, oe_n_nx, frame_start_nx;
  logic          lit_nx;

  assign grid_row = {12'd0, row};

`ifdef SCAN_BRIGHTNESS_EN
  logic [3:0]    bright_q;
  logic [CW+4:0] duty;

  // Hold the brightness seen in LOAD so the whole row uses one duty value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bright_q <= 4'd0;
    end else if (state == ST_LOAD) begin
      bright_q <= brightness;
    end
  end

  assign duty   = (((CW+5)'(bright_q) + (CW+5)'(1)) * (CW+5)'(DWELL)) >> 4;
  assign lit_nx = ({5'd0, cnt_nx} < duty);
`else
  assign lit_nx = 1'b1;
`endif

  // Next-state logic; outputs are derived from the next state so they can be registered
  always_comb begin
    state_nx   = state;
    row_nx     = row;
    bit_cnt_nx = bit_cnt;
    cnt_nx     = cnt;
    shreg_nx   = shreg;
    case (state)
      ST_IDLE: begin
        if (en) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        shreg_nx   = {16'h8000 >> row, grid_col};
        bit_cnt_nx = 5'd31;
        cnt_nx     = '0;
        state_nx   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt == CW'(SHIFT_LAST)) begin
          shreg_nx   = {shreg[30:0], 1'b0};
          bit_cnt_nx = bit_cnt - 5'd1;
          cnt_nx     = '0;
          if (bit_cnt == 5'd0) state_nx = ST_LATCH;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      ST_LATCH: begin
        if (cnt == CW'(CLK_DIV - 1)) begin
          cnt_nx   = '0;
          state_nx = ST_DWELL;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      ST_DWELL: begin
        if (cnt == CW'(DWELL - 1)) begin
          cnt_nx   = '0;
          row_nx   = row + 4'd1;
          state_nx = en ? ST_LOAD : ST_IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    ser_data_nx    = (state_nx == ST_SHIFT) && shreg_nx[31];
    ser_clk_nx     = (state_nx == ST_SHIFT) && (cnt_nx >= CW'(CLK_DIV));
    ser_latch_nx   = (state_nx == ST_LATCH);
    oe_n_nx        = !((state_nx == ST_DWELL) && lit_nx);
    frame_start_nx = (state_nx == ST_LOAD) && (row_nx == 4'd0);
  end

  // State, counters and registered outputs; reset aborts any row in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      row         <= 4'd0;
      bit_cnt     <= 5'd0;
      cnt         <= '0;
      shreg       <= 32'd0;
      ser_data    <= 1'b0;
      ser_clk     <= 1'b0;
      ser_latch   <= 1'b0;
      oe_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nx;
      row         <= row_nx;
      bit_cnt     <= bit_cnt_nx;
      cnt         <= cnt_nx;
      shreg       <= shreg_nx;
      ser_data    <= ser_data_nx;
      ser_clk     <= ser_clk_nx;
      ser_latch   <= ser_latch_nx;
      oe_n        <= oe_n_nx;
      frame_start <= frame_start_nx;
    end
  end

endmodule
